// File: rtl/apb_regbank_slv.sv
// APB completer: read-only ID register plus a byte-strobed register bank.
// Programmable wait states; pready, prdata and pslverr are registered.
module apb_regbank_slv #(
  parameter int          D_WIDTH     = 64,
  parameter int          NREGS       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2,
  parameter logic [63:0] ID_VALUE    = 64'hA5B0_0001_0000_0001
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic [31:0]              paddr,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [D_WIDTH-1:0]       pwdata,
  input  logic [D_WIDTH/8-1:0]     pstrb,
  output logic                     pready,
  output logic [D_WIDTH-1:0]       prdata,
  output logic                     pslverr,
  output logic [NREGS*D_WIDTH-1:0] reg_q
);

  localparam int BW = D_WIDTH / 8;
  localparam int AW = $clog2(BW);
  localparam int IW = $clog2(NREGS);
  localparam logic [31:0] SPAN = 32'(NREGS * BW);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [D_WIDTH-1:0] ID =
    ID_VALUE[D_WIDTH-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic                 pready_q;
  logic                 pslverr_q;
  logic [D_WIDTH-1:0]   prdata_q;
  logic [D_WIDTH-1:0]   regs_q [1:NREGS-1];

  logic [31:0]          off;
  logic [IW-1:0]        idx;
  logic                 mis;
  logic                 oor;
  logic                 bad;
  logic                 hit;
  logic                 wr_en;
  logic [D_WIDTH-1:0]   rd_val;

  assign off    = paddr - BASE_ADDR;
  assign idx    = off[AW +: IW];
  assign mis    = |off[AW-1:0];
  assign oor    = off >= SPAN;
  assign bad    = mis | oor | (pwrite & (idx == '0));
  assign hit    = psel & penable;
  assign rd_val = reg_q[idx*D_WIDTH +: D_WIDTH];

  // Slot 0 is the constant ID; it has no storage behind it.
  assign reg_q[D_WIDTH-1:0] = ID;
  for (genvar k = 1; k < NREGS; k++) begin : g_flat
    assign reg_q[k*D_WIDTH +: D_WIDTH] = regs_q[k];
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (hit) begin
            state_q <= S_WAIT;
            cnt_q   <= WS;
          end
        end
        S_WAIT: begin
          if (!hit) begin
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            state_q   <= S_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= bad;
            prdata_q  <= (pwrite | bad) ? '0 : rd_val;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q   <= S_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The write lands on the completing edge, only if the master held the beat.
  assign wr_en = (state_q == S_RESP) & hit & pwrite & ~bad;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int k = 1; k < NREGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (wr_en) begin
      for (int k = 1; k < NREGS; k++) begin
        for (int i = 0; i < BW; i++) begin
          if (idx == IW'(k) && pstrb[i]) begin
            regs_q[k][8*i +: 8] <= pwdata[8*i +: 8];
          end
        end
      end
    end
  end

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_regbank_slv.sv
// Directed bench for apb_regbank_slv: reset, strobes, errors,
// wait-state latency, aborts and a randomly paced burst.
module tb_apb_regbank_slv;

  localparam logic [63:0] ID = 64'hA5B0_0001_0000_0001;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic [31:0]   paddr = '0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [63:0]   pwdata = '0;
  logic [7:0]    pstrb = '0;
  logic          pready, pready0, pready7;
  logic [63:0]   prdata, prdata0, prdata7;
  logic          pslverr, pslverr0, pslverr7;
  logic [1023:0] reg_q, regq0, regq7;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  apb_regbank_slv #(.WAIT_STATES(2)) dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .reg_q(reg_q)
  );

  apb_regbank_slv #(.WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready0),
    .prdata(prdata0), .pslverr(pslverr0), .reg_q(regq0)
  );

  apb_regbank_slv #(.WAIT_STATES(7)) u_ws7 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready7),
    .prdata(prdata7), .pslverr(pslverr7), .reg_q(regq7)
  );

  task automatic xfer(
    input  logic [31:0] a,
    input  logic        w,
    input  logic [63:0] d,
    input  logic [7:0]  s,
    input  int          nsetup,
    output logic [63:0] rd,
    output logic        err,
    output int          lat
  );
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0;
    paddr = a; pwrite = w; pwdata = d; pstrb = s;
    for (int i = 1; i < nsetup; i++) @(posedge pclk);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    lat = 0;
    while (!pready && lat < 40) begin
      @(posedge pclk); #1;
      lat++;
    end
    checks++;
    if (pready !== 1'b1) begin
      errors++;
      $display("FAIL timeout addr=%h got pready=%b want 1", a, pready);
    end
    rd  = prdata;
    err = pslverr;
    @(posedge pclk); #1;
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL pready_one_cycle got %b want 0", pready);
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] rd;
    logic        err;
    int          lat;
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    checks++;
    if ({pready, pslverr, prdata} !== 66'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b %b %h want 0 0 0",
               pready, pslverr, prdata);
    end
    checks++;
    if (reg_q !== {960'd0, ID} || regq0[63:0] !== ID
        || regq7[63:0] !== ID) begin
      errors++;
      $display("FAIL reset_regq got slot0=%h slot1=%h want %h 0",
               reg_q[63:0], reg_q[127:64], ID);
    end
    presetn = 1'b1;
    xfer(32'd0, 1'b0, '0, 8'h00, 1, rd, err, lat);
    checks++;
    if (rd !== ID || err !== 1'b0 || lat != 3) begin
      errors++;
      $display("FAIL read_id got %h err=%b lat=%0d want %h 0 3",
               rd, err, lat, ID);
    end
    xfer(32'd40, 1'b0, '0, 8'hFF, 1, rd, err, lat);
    checks++;
    if (rd !== 64'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL read_idx5 got %h err=%b want 0 0", rd, err);
    end
  endtask

  task automatic test_strobe();
    logic [63:0] rd;
    logic        err;
    int          lat;
    xfer(32'd24, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, 1,
         rd, err, lat);
    checks++;
    if (err !== 1'b0 || reg_q[3*64 +: 64] !== 64'h0000_0000_5566_7788) begin
      errors++;
      $display("FAIL strobe_lo got %h err=%b want 0000000055667788 0",
               reg_q[3*64 +: 64], err);
    end
    xfer(32'd24, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 2,
         rd, err, lat);
    xfer(32'd24, 1'b0, '0, 8'h00, 1, rd, err, lat);
    checks++;
    if (rd !== 64'hAAAA_BBBB_5566_7788 || err !== 1'b0) begin
      errors++;
      $display("FAIL strobe_merge got %h err=%b want aaaabbbb55667788 0",
               rd, err);
    end
  endtask

  task automatic test_errors();
    logic [63:0] rd;
    logic        err;
    int          lat;
    xfer(32'd0, 1'b1, '1, 8'hFF, 1, rd, err, lat);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL wr_id_err got %b want 1", err);
    end
    xfer(32'd0, 1'b0, '0, 8'h00, 1, rd, err, lat);
    checks++;
    if (rd !== ID || err !== 1'b0 || reg_q[63:0] !== ID) begin
      errors++;
      $display("FAIL id_kept got %h err=%b want %h 0", rd, err, ID);
    end
    xfer(32'd128, 1'b0, '0, 8'h00, 1, rd, err, lat);
    checks++;
    if (rd !== 64'd0 || err !== 1'b1) begin
      errors++;
      $display("FAIL rd_range got %h err=%b want 0 1", rd, err);
    end
    xfer(32'd8, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1,
         rd, err, lat);
    xfer(32'd12, 1'b1, 64'h5555_5555_5555_5555, 8'hFF, 1,
         rd, err, lat);
    checks++;
    if (err !== 1'b1 || reg_q[64 +: 64] !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL misalign got reg1=%h err=%b want 0123456789abcdef 1",
               reg_q[64 +: 64], err);
    end
  endtask

  task automatic test_wait_states();
    int l0 = 0, l2 = 0, l7 = 0;
    logic [63:0] d0 = '0, d2 = '0, d7 = '0;
    logic        e0 = 1'b1, e7 = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0;
    paddr = 32'd0; pwrite = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge pclk); #1;
      if (pready0 && l0 == 0) begin l0 = k; d0 = prdata0; e0 = pslverr0; end
      if (pready && l2 == 0) begin l2 = k; d2 = prdata; end
      if (pready7 && l7 == 0) begin l7 = k; d7 = prdata7; e7 = pslverr7; end
    end
    psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge pclk);
    checks++;
    if (l0 != 1 || l2 != 3 || l7 != 8) begin
      errors++;
      $display("FAIL latency got %0d %0d %0d want 1 3 8", l0, l2, l7);
    end
    checks++;
    if (d0 !== ID || d2 !== ID || d7 !== ID || e0 !== 1'b0
        || e7 !== 1'b0) begin
      errors++;
      $display("FAIL ws_data got %h %h %h err=%b%b want %h",
               d0, d2, d7, e0, e7, ID);
    end
  endtask

  task automatic test_abort();
    logic saw = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0;
    paddr = 32'd16; pwrite = 1'b1; pwdata = '1; pstrb = 8'hFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge pclk); #1;
      if (pready) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0 || reg_q[2*64 +: 64] !== 64'd0) begin
      errors++;
      $display("FAIL abort got pready_seen=%b reg2=%h want 0 0",
               saw, reg_q[2*64 +: 64]);
    end
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0;
    paddr = 32'd0; pwrite = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int k = 0; k < 10 && !pready; k++) begin
      @(posedge pclk); #1;
    end
    presetn = 1'b0;
    #1;
    checks++;
    if ({pready, pslverr, prdata} !== 66'd0
        || reg_q[3*64 +: 64] !== 64'd0) begin
      errors++;
      $display("FAIL reset_in_resp got %b %b %h reg3=%h want 0",
               pready, pslverr, prdata, reg_q[3*64 +: 64]);
    end
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge pclk); #1;
      if (pready) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready got %b want 0", saw);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] wd [4];
    logic [63:0] rd;
    logic        err;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom};
      xfer(32'(8 + 8 * i), 1'b1, wd[i], 8'hFF,
           int'($urandom_range(1, 3)), rd, err, lat);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(32'(8 + 8 * i), 1'b0, '0, 8'h00,
           int'($urandom_range(1, 3)), rd, err, lat);
      checks++;
      if (rd !== wd[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL burst_rd%0d got %h err=%b want %h 0",
                 i, rd, err, wd[i]);
      end
      checks++;
      if (reg_q[(i+1)*64 +: 64] !== wd[i]) begin
        errors++;
        $display("FAIL burst_regq%0d got %h want %h",
                 i + 1, reg_q[(i+1)*64 +: 64], wd[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_errors();
    test_wait_states();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
